// File: rtl/serial_byte_receiver.sv
// serial_byte_receiver: samples one serial bit per clock, frames it as
// start / DATA_BITS data bits (LSB first) / optional odd parity / stop,
// and reports each frame with a one-cycle done or err pulse.
module serial_byte_receiver #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY_EN = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in,
  output logic [DATA_BITS-1:0] out_byte,
  output logic                 done,
  output logic                 err
);

  localparam int unsigned CW = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic [DATA_BITS-1:0] out_q, out_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  // State and datapath registers, cleared asynchronously by active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      out_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      out_q   <= out_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state, shift/parity accumulation and registered pulse generation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    par_d   = par_q;
    out_d   = out_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!in) begin
          state_d = S_DATA;
          cnt_d   = '0;
          par_d   = 1'b0;
        end
      end

      S_DATA: begin
        // Position-by-position write avoids an index wider than the vector.
        for (int unsigned i = 0; i < DATA_BITS; i++) begin
          if (cnt_q == CW'(i)) shift_d[i] = in;
        end
        par_d = par_q ^ in;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(DATA_BITS - 1)) begin
          state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
        end
      end

      S_PARITY: begin
        par_d   = par_q ^ in;
        state_d = S_STOP;
      end

      S_STOP: begin
        if (in) begin
          state_d = S_IDLE;
          if ((PARITY_EN == 0) || par_q) begin
            out_d  = shift_q;
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          err_d   = 1'b1;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (in) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign out_byte = out_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_serial_byte_receiver.sv
// Bench for serial_byte_receiver: instance A (8 bits, no parity) and
// instance B (8 bits, odd parity) checked every cycle against a frame-level
// event schedule, plus literal spot checks.
module tb_serial_byte_receiver;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_a, in_b;
  logic [7:0] out_a, out_b;
  logic       done_a, err_a, done_b, err_b;

  serial_byte_receiver #(.DATA_BITS(8), .PARITY_EN(0)) dut_a (
    .clk(clk), .reset(reset), .in(in_a),
    .out_byte(out_a), .done(done_a), .err(err_a)
  );

  serial_byte_receiver #(.DATA_BITS(8), .PARITY_EN(1)) dut_b (
    .clk(clk), .reset(reset), .in(in_b),
    .out_byte(out_b), .done(done_b), .err(err_b)
  );

  always #5 clk = ~clk;

  int npass = 0;
  int ntotal = 0;
  int cyc = 0;

  // Frame-level model: at the stop-sampling edge of each frame, kind 1 = done
  // (out_byte takes data), kind 2 = err (out_byte held).
  int         kind_a[int];
  logic [7:0] data_a[int];
  int         kind_b[int];
  logic [7:0] data_b[int];
  logic [7:0] model_a = '0;
  logic [7:0] model_b = '0;
  int last_done_a = -100;
  int prev_done_a = -100;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
  endtask

  // Per-cycle compare, sampled 1 time unit after each rising edge.
  always @(posedge clk) begin
    logic ed, ee;
    cyc++;
    #1;
    ed = 1'b0; ee = 1'b0;
    if (kind_a.exists(cyc)) begin
      ed = (kind_a[cyc] == 1); ee = (kind_a[cyc] == 2);
      if (ed) model_a = data_a[cyc];
    end
    check("A_cycle", {22'd0, done_a, err_a, out_a}, {22'd0, ed, ee, model_a});
    if (done_a) begin prev_done_a = last_done_a; last_done_a = cyc; end
    ed = 1'b0; ee = 1'b0;
    if (kind_b.exists(cyc)) begin
      ed = (kind_b[cyc] == 1); ee = (kind_b[cyc] == 2);
      if (ed) model_b = data_b[cyc];
    end
    check("B_cycle", {22'd0, done_b, err_b, out_b}, {22'd0, ed, ee, model_b});
  end

  task automatic clear_model();
    kind_a.delete(); data_a.delete(); kind_b.delete(); data_b.delete();
    model_a = '0; model_b = '0;
  endtask

  task automatic idle_a(input int n, input logic v);
    for (int i = 0; i < n; i++) begin @(negedge clk); in_a = v; end
  endtask

  task automatic idle_b(input int n);
    for (int i = 0; i < n; i++) begin @(negedge clk); in_b = 1'b1; end
  endtask

  // Start bit sampled at edge s; stop bit at s+9.
  task automatic send_a(input logic [7:0] d, input logic stop_bit);
    int es;
    @(negedge clk);
    es = cyc + 1 + 9;
    kind_a[es] = stop_bit ? 1 : 2;
    data_a[es] = d;
    in_a = 1'b0;
    for (int i = 0; i < 8; i++) begin @(negedge clk); in_a = d[i]; end
    @(negedge clk); in_a = stop_bit;
  endtask

  // Start bit at edge s, parity at s+9, stop at s+10.
  task automatic send_b(input logic [7:0] d, input logic par, input logic stop_bit);
    int es;
    int ones;
    @(negedge clk);
    es = cyc + 1 + 10;
    ones = $countones(d) + int'(par);
    kind_b[es] = (stop_bit && (ones % 2 == 1)) ? 1 : 2;
    data_b[es] = d;
    in_b = 1'b0;
    for (int i = 0; i < 8; i++) begin @(negedge clk); in_b = d[i]; end
    @(negedge clk); in_b = par;
    @(negedge clk); in_b = stop_bit;
  endtask

  initial begin
    logic [7:0] partial;
    reset = 1'b0; in_a = 1'b1; in_b = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_out_a", {24'd0, out_a}, 32'h0);
    check("reset_pulses", {30'd0, done_a, err_a}, 32'h0);
    reset = 1'b1;
    idle_a(2, 1'b1);

    // Single frame 0xA5.
    send_a(8'hA5, 1'b1);
    idle_a(3, 1'b1);
    check("a5_literal", {24'd0, out_a}, 32'h0000_00A5);

    // Asynchronous reset between edges, checked before any edge.
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_out_a", {24'd0, out_a}, 32'h0);
    check("async_pulses", {28'd0, done_a, err_a, done_b, err_b}, 32'h0);
    clear_model();
    @(negedge clk); reset = 1'b1;
    idle_a(2, 1'b1);

    // Back-to-back 0x3C then 0xFF.
    send_a(8'h3C, 1'b1);
    send_a(8'hFF, 1'b1);
    idle_a(3, 1'b1);
    check("b2b_gap", last_done_a - prev_done_a, 32'd10);
    check("b2b_last", {24'd0, out_a}, 32'h0000_00FF);

    // Framing error, line held low, then recovery with 0x12.
    send_a(8'h55, 1'b0);
    idle_a(5, 1'b0);
    check("frame_err_hold", {24'd0, out_a}, 32'h0000_00FF);
    idle_a(1, 1'b1);
    send_a(8'h12, 1'b1);
    idle_a(3, 1'b1);
    check("recover_12", {24'd0, out_a}, 32'h0000_0012);

    // Reset after 4 data bits of a frame: partial frame is discarded.
    partial = 8'hAA;
    @(negedge clk); in_a = 1'b0;
    for (int i = 0; i < 4; i++) begin @(negedge clk); in_a = partial[i]; end
    @(negedge clk);
    in_a = 1'b1;
    reset = 1'b0;
    clear_model();
    #2 reset = 1'b1;
    idle_a(12, 1'b1);
    send_a(8'hC3, 1'b1);
    idle_a(3, 1'b1);
    check("midreset_c3", {24'd0, out_a}, 32'h0000_00C3);

    // Odd parity on instance B.
    send_b(8'h01, 1'b0, 1'b1);
    idle_b(3);
    check("par_ok_01", {24'd0, out_b}, 32'h0000_0001);
    send_b(8'h01, 1'b1, 1'b1);
    idle_b(3);
    check("par_bad_hold", {24'd0, out_b}, 32'h0000_0001);
    send_b(8'h96, 1'b1, 1'b1);
    idle_b(3);
    check("par_ok_96", {24'd0, out_b}, 32'h0000_0096);

    @(negedge clk);
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
